// File: rtl/uart_tx_frame_if.sv
// Transmit request/status bundle between a UART client and uart_tx_frame.
interface uart_tx_frame_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx;

  modport master (output tx_data, tx_start, input tx_busy, tx_done, tx);
  modport slave  (input tx_data, tx_start, output tx_busy, tx_done, tx);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1 stop bit.
// Latency: tx falls on the edge that accepts tx_start; frame is (10 + PARITY_EN) bit times.
// Backpressure: tx_start is ignored (not queued) while tx_busy is high.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_frame_if.slave tx_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (baud_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // tx is computed one edge ahead so the pin is a plain flop output.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_if.tx_start) begin
          shift_d = tx_if.tx_data;
          par_d   = (^tx_if.tx_data) ^ PARITY_ODD;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_if.tx      = tx_q;
  assign tx_if.tx_busy = busy_q;
  assign tx_if.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: even-parity, odd-parity and no-parity instances on one clock,
// frames sampled at bit centres and compared against a queued reference model.
module tb_uart_tx_frame;
  localparam int N = 434;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  uart_tx_frame_if ife ();
  uart_tx_frame_if ifo ();
  uart_tx_frame_if ifn ();

  uart_tx_frame #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
    dut_even (.clk(clk), .rst(rst), .tx_if(ife));
  uart_tx_frame #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
    dut_odd  (.clk(clk), .rst(rst), .tx_if(ifo));
  uart_tx_frame #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    dut_nopar (.clk(clk), .rst(rst), .tx_if(ifn));

  logic [2:0] tx_w, busy_w, done_w;
  assign tx_w   = {ifn.tx, ifo.tx, ife.tx};
  assign busy_w = {ifn.tx_busy, ifo.tx_busy, ife.tx_busy};
  assign done_w = {ifn.tx_done, ifo.tx_done, ife.tx_done};

  int checks = 0;
  int failures = 0;
  logic [10:0] sb[$];

  int cyc = 0;
  int done_cnt[3] = '{0, 0, 0};
  int busy_cnt[3] = '{0, 0, 0};
  int rise_cyc[3] = '{0, 0, 0};
  logic [2:0] tx_prev = 3'b111;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_w[i] === 1'b1) done_cnt[i]++;
      if (busy_w[i] === 1'b1) busy_cnt[i]++;
      if (tx_w[i] === 1'b1 && tx_prev[i] === 1'b0) rise_cyc[i] = cyc;
    end
    tx_prev = tx_w;
  end

  // Reference frame: bit 0 start, bits 8:1 data LSB first, then parity/stop.
  function automatic logic [10:0] model(input logic [7:0] d, input bit pe, input bit po);
    logic [10:0] f;
    f = '0;
    f[8:1] = d;
    if (pe) begin
      f[9]  = (^d) ^ po;
      f[10] = 1'b1;
    end else begin
      f[9] = 1'b1;
    end
    return f;
  endfunction

  task automatic drive(input int sel, input logic [7:0] d, input logic s);
    case (sel)
      0: begin ife.tx_data = d; ife.tx_start = s; end
      1: begin ifo.tx_data = d; ifo.tx_start = s; end
      default: begin ifn.tx_data = d; ifn.tx_start = s; end
    endcase
  endtask

  task automatic send(input int sel, input logic [7:0] d);
    @(posedge clk); #1;
    drive(sel, d, 1'b1);
    @(posedge clk); #1;
    drive(sel, d, 1'b0);
    sb.push_back(model(d, sel != 2, sel == 1));
  endtask

  task automatic receive(input int sel, input int nb, output logic [10:0] bits,
                         output int fall_c, output int done_c, output bit ok);
    int n;
    bits = '0; ok = 1'b1; fall_c = 0; done_c = 0; n = 0;
    @(negedge clk);
    while (tx_w[sel] !== 1'b0 && n < 3 * 11 * N) begin @(negedge clk); n++; end
    if (tx_w[sel] !== 1'b0) begin ok = 1'b0; return; end
    fall_c = cyc;
    repeat (N / 2) @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      bits[k] = tx_w[sel];
      if (k < nb - 1) repeat (N) @(negedge clk);
    end
    n = 0;
    while (done_w[sel] !== 1'b1 && n < 2 * N) begin @(negedge clk); n++; end
    if (done_w[sel] !== 1'b1) ok = 1'b0;
    done_c = cyc;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({tx_w[i], busy_w[i], done_w[i]} !== 3'b100) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: got tx/busy/done=%b want 100", i, {tx_w[i], busy_w[i], done_w[i]});
      end
    end
    #5 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_w !== 3'b111 || busy_w !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: got tx=%b busy=%b want tx=111 busy=000", tx_w, busy_w);
    end
  endtask

  task automatic test_even_0c();
    logic [10:0] bits, exp;
    int f, d, dc;
    bit ok;
    dc = done_cnt[0];
    send(0, 8'h0C);
    receive(0, 11, bits, f, d, ok);
    exp = sb.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL even_0c_timeout: got no frame/done want frame"); end
    checks++;
    if (bits !== exp) begin failures++; $display("FAIL even_0c_frame: got %b want %b", bits, exp); end
    checks++;
    if (bits !== 11'b10000011000) begin failures++; $display("FAIL even_0c_bits: got %b want 10000011000", bits); end
    checks++;
    if (d - f !== 11 * N) begin failures++; $display("FAIL even_0c_latency: got %0d want %0d", d - f, 11 * N); end
    checks++;
    if (done_cnt[0] - dc !== 1) begin failures++; $display("FAIL even_0c_done_count: got %0d want 1", done_cnt[0] - dc); end
    checks++;
    if (bits[8:1] !== 8'h0C) begin failures++; $display("FAIL even_0c_loopback: got %h want 0c", bits[8:1]); end
  endtask

  task automatic test_parity_aa();
    logic [10:0] bits, exp;
    int f, d;
    bit ok;
    send(1, 8'hAA);
    receive(1, 11, bits, f, d, ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || bits !== exp) begin failures++; $display("FAIL odd_aa_frame: got %b want %b", bits, exp); end
    checks++;
    if (bits[9] !== 1'b1) begin failures++; $display("FAIL odd_aa_parity: got %b want 1", bits[9]); end
    send(0, 8'hAA);
    receive(0, 11, bits, f, d, ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || bits !== exp) begin failures++; $display("FAIL even_aa_frame: got %b want %b", bits, exp); end
    checks++;
    if (bits[9] !== 1'b0) begin failures++; $display("FAIL even_aa_parity: got %b want 0", bits[9]); end
  endtask

  task automatic test_no_parity();
    logic [10:0] bits, exp;
    int f, d, bc;
    bit ok;
    bc = busy_cnt[2];
    send(2, 8'h08);
    receive(2, 10, bits, f, d, ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || bits !== exp) begin failures++; $display("FAIL nopar_08_frame: got %b want %b", bits, exp); end
    checks++;
    if (bits !== 11'b01000010000) begin failures++; $display("FAIL nopar_08_bits: got %b want 01000010000", bits); end
    checks++;
    if (busy_cnt[2] - bc !== 10 * N) begin failures++; $display("FAIL nopar_busy_len: got %0d want %0d", busy_cnt[2] - bc, 10 * N); end
    checks++;
    if (d - f !== 10 * N) begin failures++; $display("FAIL nopar_latency: got %0d want %0d", d - f, 10 * N); end
  endtask

  task automatic test_busy_ignore();
    logic [10:0] bits, exp;
    int f, d, dc, lows;
    bit ok;
    dc = done_cnt[0];
    send(0, 8'h55);
    fork
      receive(0, 11, bits, f, d, ok);
      begin
        repeat (1000) @(posedge clk);
        #1 drive(0, 8'hFF, 1'b1);
        @(posedge clk); #1 drive(0, 8'h00, 1'b0);
      end
    join
    exp = sb.pop_front();
    checks++;
    if (!ok || bits !== exp) begin failures++; $display("FAIL busy_ignore_frame: got %b want %b", bits, exp); end
    lows = 0;
    repeat (3 * N) begin @(negedge clk); if (tx_w[0] !== 1'b1) lows++; end
    checks++;
    if (lows !== 0) begin failures++; $display("FAIL busy_ignore_idle: got %0d low cycles want 0", lows); end
    checks++;
    if (done_cnt[0] - dc !== 1) begin failures++; $display("FAIL busy_ignore_done_count: got %0d want 1", done_cnt[0] - dc); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] b1, b2, e1, e2;
    int f1, d1, f2, d2, rise;
    bit ok1, ok2;
    @(posedge clk); #1 drive(0, 8'h0C, 1'b1);
    sb.push_back(model(8'h0C, 1'b1, 1'b0));
    receive(0, 11, b1, f1, d1, ok1);
    drive(0, 8'h08, 1'b1);
    sb.push_back(model(8'h08, 1'b1, 1'b0));
    rise = rise_cyc[0];
    fork
      receive(0, 11, b2, f2, d2, ok2);
      begin @(posedge clk); #1 drive(0, 8'h08, 1'b0); end
    join
    e1 = sb.pop_front();
    e2 = sb.pop_front();
    checks++;
    if (!ok1 || b1 !== e1) begin failures++; $display("FAIL b2b_frame1: got %b want %b", b1, e1); end
    checks++;
    if (!ok2 || b2 !== e2) begin failures++; $display("FAIL b2b_frame2: got %b want %b", b2, e2); end
    checks++;
    if (d1 - rise !== N) begin failures++; $display("FAIL b2b_stop_len: got %0d want %0d", d1 - rise, N); end
    checks++;
    if (f2 - d1 !== 1) begin failures++; $display("FAIL b2b_gap: got %0d want 1", f2 - d1); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits, exp;
    int f, d, dc;
    bit ok;
    send(0, 8'h0C);
    exp = sb.pop_back();
    repeat (4 * N + N / 2) @(posedge clk);
    #3;
    checks++;
    if (busy_w[0] !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b want 1", busy_w[0]); end
    dc = done_cnt[0];
    rst = 1'b0;
    #1;
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_async_reset: got tx=%b busy=%b want tx=1 busy=0", tx_w[0], busy_w[0]);
    end
    repeat (5) @(negedge clk);
    #5 rst = 1'b1;
    repeat (2 * N) @(negedge clk);
    checks++;
    if (done_cnt[0] !== dc || tx_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_no_done: got done_delta=%0d tx=%b want 0 and 1", done_cnt[0] - dc, tx_w[0]);
    end
    send(0, 8'h08);
    receive(0, 11, bits, f, d, ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || bits !== exp) begin failures++; $display("FAIL mid_new_frame: got %b want %b", bits, exp); end
    checks++;
    if (bits !== 11'b11000010000) begin failures++; $display("FAIL mid_new_bits: got %b want 11000010000", bits); end
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    drive(2, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    test_reset();
    test_even_0c();
    test_parity_aa();
    test_no_parity();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_left: got %0d want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
